// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter, receiver and the
// transmit arbiter.
//   arb_state_t    - arbiter state encoding (IDLE / START / WAIT)
//   D_BIT_DEFAULT  - default number of data bits per frame
//   SB_TICK        - s_tick count for one stop bit
//   ptr_width()    - width of a round-robin pointer over n requesters
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    localparam int unsigned D_BIT_DEFAULT = 8;
    localparam int unsigned SB_TICK       = 16;

    // A pointer is always at least one bit wide, even for a single requester.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick.
// Scans req_i upward from index ptr_i, wrapping modulo N, and returns the
// first set bit as a one-hot vector.
//   req_i  [N]  - request vector
//   ptr_i  [PW] - index where the scan starts (< N)
//   pick_o [N]  - one-hot winner, zero when no request
//   any_o       - at least one request present
module rr_priority_picker #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  pick_o,
    output logic          any_o
);

    always_comb begin
        logic        found;
        int unsigned idx;
        pick_o = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among
// N_REQ byte producers.
//   clk, rst           - clock, asynchronous active-high reset
//   req_valid/req_data - per-requester byte handshake (data slice i*D_BIT)
//   req_last           - last byte of a packet (lock feature only)
//   req_ready          - one-hot, one-cycle consume pulse
//   grant              - one-hot owner of the current transfer, 0 when idle
//   busy               - transfer in progress
//   tx_start, tx_din   - launch pulse and byte to the transmitter
//   tx_done_tick       - transmitter finished the stop bit
// Optional feature: define UART_ARB_LOCK_EN to keep the grant on one
// requester until it sends a byte flagged req_last.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned D_BIT = D_BIT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*D_BIT-1:0] req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic                   tx_start,
    output logic [D_BIT-1:0]       tx_din,
    input  logic                   tx_done_tick
);

    localparam int unsigned PW = ptr_width(N_REQ);

    arb_state_t        state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [D_BIT-1:0]  tx_din_q, tx_din_d;

    logic [N_REQ-1:0]  pick_req;
    logic [PW-1:0]     pick_ptr;
    logic [N_REQ-1:0]  pick;
    logic              pick_any;
    logic [D_BIT-1:0]  sel_din;
    logic              sel_last;
    logic [PW-1:0]     grant_idx;
    logic [PW-1:0]     next_ptr;

`ifdef UART_ARB_LOCK_EN
    logic              lock_vld_q, lock_vld_d;
    logic [PW-1:0]     lock_idx_q, lock_idx_d;
    logic              last_q, last_d;
    logic [N_REQ-1:0]  lock_mask;

    // While locked, only the owner is visible and the scan starts on it.
    always_comb begin
        lock_mask = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            lock_mask[i] = (PW'(i) == lock_idx_q);
        end
    end

    assign pick_req = lock_vld_q ? (req_valid & lock_mask) : req_valid;
    assign pick_ptr = lock_vld_q ? lock_idx_q : rr_ptr_q;
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign pick_req    = req_valid;
    assign pick_ptr    = rr_ptr_q;
`endif

    rr_priority_picker #(
        .N  (N_REQ),
        .PW (PW)
    ) u_picker (
        .req_i  (pick_req),
        .ptr_i  (pick_ptr),
        .pick_o (pick),
        .any_o  (pick_any)
    );

    always_comb begin
        sel_din   = '0;
        sel_last  = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                sel_din  = req_data[i*D_BIT +: D_BIT];
                sel_last = req_last[i];
            end
            if (grant_q[i]) begin
                grant_idx = PW'(i);
            end
        end
        next_ptr = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        tx_din_d = tx_din_q;
`ifdef UART_ARB_LOCK_EN
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        last_d     = last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d  = ST_START;
                    grant_d  = pick;
                    tx_din_d = sel_din;
`ifdef UART_ARB_LOCK_EN
                    last_d   = sel_last;
`endif
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done_tick) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
`ifdef UART_ARB_LOCK_EN
                    // Mid-packet: hold the owner and freeze the pointer.
                    if (!last_q) begin
                        lock_vld_d = 1'b1;
                        lock_idx_d = grant_idx;
                    end else begin
                        lock_vld_d = 1'b0;
                        rr_ptr_d   = next_ptr;
                    end
`else
                    rr_ptr_d = next_ptr;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            tx_din_q <= '0;
`ifdef UART_ARB_LOCK_EN
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
            last_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            tx_din_q <= tx_din_d;
`ifdef UART_ARB_LOCK_EN
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
            last_q     <= last_d;
`endif
        end
    end

    // Outputs decode registers only; nothing combinational from the inputs.
    assign busy      = (state_q != ST_IDLE);
    assign tx_start  = (state_q == ST_START);
    assign req_ready = (state_q == ST_START) ? grant_q : '0;
    assign grant     = grant_q;
    assign tx_din    = tx_din_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*DB-1:0] req_data = '0;
    logic [N-1:0]  req_last = '0;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  grant;
    logic          busy;
    logic          tx_start;
    logic [DB-1:0] tx_din;
    logic          tx_done_tick = 1'b0;

    int checks = 0;
    int failures = 0;

    uart_tx_arbiter #(.N_REQ(N), .D_BIT(DB)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant        (grant),
        .busy         (busy),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        tx_done_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic last);
        req_valid[i] = 1'b1;
        req_data[i*DB +: DB] = d;
        req_last[i] = last;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++; if (grant !== 4'b0) begin failures++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        checks++; if (tx_din !== 8'h00) begin failures++; $display("FAIL reset_tx_din: got %h expected 00", tx_din); end
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        do_reset();
    endtask

    task automatic test_single();
        @(negedge clk);
        set_req(2, 8'hA5, 1'b1);
        @(posedge clk); #1;
        checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL single_start: got %b expected 1", tx_start); end
        checks++; if (tx_din !== 8'hA5) begin failures++; $display("FAIL single_din: got %h expected a5", tx_din); end
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL single_grant: got %b expected 0100", grant); end
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready !== 4'b0 || tx_start !== 1'b0 || busy !== 1'b1)
            begin failures++; $display("FAIL single_wait: got ready=%b start=%b busy=%b expected 0000 0 1", req_ready, tx_start, busy); end
        repeat (3) @(negedge clk);
        pulse_done();
        checks++; if (busy !== 1'b0 || grant !== 4'b0)
            begin failures++; $display("FAIL single_done: got busy=%b grant=%b expected 0 0000", busy, grant); end
    endtask

    task automatic test_all_four();
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 + i), 1'b1);
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            checks++; if (grant !== 4'(1 << (n % 4)) || tx_din !== 8'(8'h10 + n % 4) || tx_start !== 1'b1)
                begin failures++; $display("FAIL all_four_%0d: got grant=%b din=%h start=%b expected %b %h 1", n, grant, tx_din, tx_start, 4'(1 << (n % 4)), 8'(8'h10 + n % 4)); end
            @(negedge clk);
            if (n == 5) req_valid = '0;
            pulse_done();
        end
    endtask

    task automatic test_wait_block();
        bit seen;
        do_reset();
        set_req(3, 8'h33, 1'b1);
        @(posedge clk); #1;
        checks++; if (grant !== 4'b1000 || tx_start !== 1'b1)
            begin failures++; $display("FAIL wblk_first: got grant=%b start=%b expected 1000 1", grant, tx_start); end
        @(negedge clk);
        req_valid[3] = 1'b0;
        set_req(1, 8'h11, 1'b1);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (tx_start === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL wblk_hold: got start_seen=%b expected 0", seen); end
        pulse_done();
        @(posedge clk); #1;
        checks++; if (grant !== 4'b0010 || tx_din !== 8'h11 || tx_start !== 1'b1)
            begin failures++; $display("FAIL wblk_next: got grant=%b din=%h start=%b expected 0010 11 1", grant, tx_din, tx_start); end
        @(negedge clk);
        req_valid[1] = 1'b0;
        pulse_done();
    endtask

    task automatic test_spurious();
        // pointer is now 2 (last owner was requester 1)
        pulse_done();
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (busy !== 1'b0 || req_ready !== 4'b0 || tx_start !== 1'b0 || grant !== 4'b0)
                begin failures++; $display("FAIL spurious_idle: got busy=%b ready=%b start=%b grant=%b expected all 0", busy, req_ready, tx_start, grant); end
        end
        @(negedge clk);
        set_req(0, 8'h0A, 1'b1);
        set_req(2, 8'h2A, 1'b1);
        @(posedge clk); #1;
        checks++; if (grant !== 4'b0100 || tx_din !== 8'h2A)
            begin failures++; $display("FAIL spurious_ptr: got grant=%b din=%h expected 0100 2a", grant, tx_din); end
        @(negedge clk);
        req_valid = '0;
        pulse_done();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_req(2, 8'h5C, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        req_valid[2] = 1'b0;
        set_req(1, 8'h77, 1'b1);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (grant !== 4'b0 || busy !== 1'b0 || tx_start !== 1'b0 || req_ready !== 4'b0 || tx_din !== 8'h00)
            begin failures++; $display("FAIL rmid_clear: got grant=%b busy=%b start=%b ready=%b din=%h expected all 0", grant, busy, tx_start, req_ready, tx_din); end
        @(posedge clk); #1;
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL rmid_noready: got %b expected 0000", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (grant !== 4'b0010 || tx_din !== 8'h77 || req_ready !== 4'b0010)
            begin failures++; $display("FAIL rmid_fresh: got grant=%b din=%h ready=%b expected 0010 77 0010", grant, tx_din, req_ready); end
        @(negedge clk);
        req_valid = '0;
        pulse_done();
    endtask

    task automatic test_packet();
        int order[$];
        logic [7:0] pkt[3];
        int sent0;
        int exp;
        logic [7:0] expd;
`ifdef UART_ARB_LOCK_EN
        order = '{0, 0, 0, 1};
`else
        order = '{0, 1, 0, 1, 0};
`endif
        pkt[0] = 8'hB0; pkt[1] = 8'hB1; pkt[2] = 8'hB2;
        sent0 = 0;
        do_reset();
        set_req(0, pkt[0], 1'b0);
        set_req(1, 8'hC1, 1'b1);
        for (int n = 0; n < order.size(); n++) begin
            exp = order[n];
            expd = (exp == 0) ? pkt[sent0] : 8'hC1;
            @(posedge clk); #1;
            checks++; if (grant !== 4'(1 << exp) || tx_din !== expd)
                begin failures++; $display("FAIL packet_%0d: got grant=%b din=%h expected %b %h", n, grant, tx_din, 4'(1 << exp), expd); end
            @(negedge clk);
            if (exp == 0) begin
                sent0++;
                if (sent0 == 3) req_valid[0] = 1'b0;
                else set_req(0, pkt[sent0], sent0 == 2);
            end
            if (n == order.size() - 1) req_valid = '0;
            pulse_done();
        end
    endtask

    task automatic test_random();
        int ptr_m;
        int lock_m;
        int exp;
        logic [7:0] d_m[N];
        logic last_m[N];
        int w;
        do_reset();
        ptr_m = 0;
        lock_m = -1;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    d_m[i] = 8'($urandom);
                    last_m[i] = 1'($urandom_range(1, 0));
                    set_req(i, d_m[i], last_m[i]);
                end
            end
            if (lock_m >= 0 && !req_valid[lock_m]) begin
                d_m[lock_m] = 8'($urandom);
                last_m[lock_m] = 1'($urandom_range(1, 0));
                set_req(lock_m, d_m[lock_m], last_m[lock_m]);
            end
            if (req_valid == '0) begin
                w = $urandom_range(N - 1, 0);
                d_m[w] = 8'($urandom);
                last_m[w] = 1'($urandom_range(1, 0));
                set_req(w, d_m[w], last_m[w]);
            end
            exp = -1;
            if (lock_m >= 0) exp = lock_m;
            else for (int k = 0; k < N; k++)
                if (exp < 0 && req_valid[(ptr_m + k) % N]) exp = (ptr_m + k) % N;
            @(posedge clk); #1;
            checks++; if (tx_start !== 1'b1 || grant !== 4'(1 << exp) || req_ready !== 4'(1 << exp) || tx_din !== d_m[exp])
                begin failures++; $display("FAIL rand_%0d: got start=%b grant=%b ready=%b din=%h expected 1 %b %b %h", r, tx_start, grant, req_ready, tx_din, 4'(1 << exp), 4'(1 << exp), d_m[exp]); end
            @(negedge clk);
            req_valid[exp] = 1'b0;
            w = $urandom_range(4, 1);
            repeat (w) @(negedge clk);
            if ($urandom_range(1, 0) == 1) begin
                w = $urandom_range(N - 1, 0);
                if (!req_valid[w]) begin
                    d_m[w] = 8'($urandom);
                    last_m[w] = 1'($urandom_range(1, 0));
                    set_req(w, d_m[w], last_m[w]);
                end
            end
            checks++; if (tx_start !== 1'b0 || busy !== 1'b1)
                begin failures++; $display("FAIL rand_wait_%0d: got start=%b busy=%b expected 0 1", r, tx_start, busy); end
            pulse_done();
            checks++; if (busy !== 1'b0 || grant !== 4'b0)
                begin failures++; $display("FAIL rand_done_%0d: got busy=%b grant=%b expected 0 0000", r, busy, grant); end
`ifdef UART_ARB_LOCK_EN
            if (!last_m[exp]) lock_m = exp;
            else begin
                lock_m = -1;
                ptr_m = (exp + 1) % N;
            end
`else
            ptr_m = (exp + 1) % N;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_wait_block();
        test_spurious();
        test_reset_mid();
        test_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
